i2c_write_sequencer: RTL

- Upstream command source for the single-byte I2C master wrapper.
- Walks an external write table of {last, delay, slave address, data} entries.
- For each entry: issues one write-start pulse, waits for the master's busy cycle to finish, checks the error flag, then applies the programmed post-write delay.
- Used for sensor and codec power-up register initialisation without a CPU.

---
 rtl/i2c_seq_pkg.sv | 31 +++
 rtl/i2c_seq_tick_timer.sv | 45 ++++
 rtl/i2c_write_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types and entry-field layout for the I2C write sequencer.
package i2c_seq_pkg;

   localparam int ENTRY_W  = 24;
   localparam int LAST_BIT = 23;
   localparam int DLY_MSB  = 22;
   localparam int DLY_LSB  = 15;
   localparam int ADDR_MSB = 14;
   localparam int ADDR_LSB = 8;
   localparam int DATA_MSB = 7;
   localparam int DATA_LSB = 0;
   localparam int DLY_W    = DLY_MSB - DLY_LSB + 1;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      LATCH,
      ISSUE,
      WAIT_HI,
      WAIT_LO,
      DELAY,
      NEXT,
      DONE,
      ERR
   } seq_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/i2c_seq_tick_timer.sv
// Loadable down-counter, either raw (one count per cycle) or prescaled by TICK_CYCLES.
// o_expire marks the final cycle of the loaded interval.
module i2c_seq_tick_timer
   import i2c_seq_pkg::*;
#(
   parameter int TICK_CYCLES = 1000,
   parameter int CNT_W       = 12
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_prescale,
   input  logic [CNT_W-1:0] i_count,
   output logic             o_expire
);

   localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   logic [CNT_W-1:0] r_count;
   logic [PRE_W-1:0] r_pre;
   logic             r_prescale;
   logic             w_step;

   assign w_step   = !r_prescale || (r_pre == PRE_W'(TICK_CYCLES - 1));
   assign o_expire = w_step && (r_count == CNT_W'(1));

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count    <= '0;
         r_pre      <= '0;
         r_prescale <= 1'b0;
      end else if (i_load) begin
         r_count    <= i_count;
         r_pre      <= '0;
         r_prescale <= i_prescale;
      end else if (r_count != '0) begin
         if (r_prescale)
            r_pre <= (r_pre == PRE_W'(TICK_CYCLES - 1)) ? '0 : r_pre + 1'b1;
         if (w_step)
            r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/i2c_write_sequencer.sv
// Walks a write table and drives a single-byte I2C master, one entry at a time.
// Per-entry retries are compiled in when I2C_SEQ_RETRY_EN is defined.
module i2c_write_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int NUM_CMDS     = 16,
   parameter int TICK_CYCLES  = 1000,
   parameter int BUSY_TIMEOUT = 4095,
`ifdef I2C_SEQ_RETRY_EN
   parameter int MAX_RETRIES  = 3,
`endif
   localparam int IDX_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
)(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   output logic [IDX_W-1:0]   o_tbl_idx,
   input  logic [ENTRY_W-1:0] i_tbl_entry,
   output logic [6:0]         o_i2c_slave_addr,
   output logic [7:0]         o_i2c_wr_byte,
   output logic               o_i2c_wr_start,
   input  logic               i_i2c_busy,
   input  logic               i_i2c_error,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_error,
   output logic [IDX_W-1:0]   o_fail_idx
`ifdef I2C_SEQ_RETRY_EN
   ,output logic [7:0]        o_retry_cnt
`endif
);

   localparam int CNT_W = max_int(DLY_W, $clog2(BUSY_TIMEOUT + 1));

   seq_state_t       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_tbl_idx, r_fail_idx;
   logic [6:0]       r_addr;
   logic [7:0]       r_data;
   logic [DLY_W-1:0] r_delay;
   logic             r_last;
   logic             r_wr_start, r_busy, r_done, r_error;
   logic             w_tmr_load, w_tmr_prescale, w_tmr_expire;
   logic [CNT_W-1:0] w_tmr_count;
   logic             w_fail, w_retry_ok;

`ifdef I2C_SEQ_RETRY_EN
   localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   logic [RETRY_W-1:0] r_retries;
   logic [7:0]         r_retry_cnt;
   assign w_retry_ok  = (r_retries < RETRY_W'(MAX_RETRIES));
   assign o_retry_cnt = r_retry_cnt;
`else
   assign w_retry_ok = 1'b0;
`endif

   i2c_seq_tick_timer #(
      .TICK_CYCLES(TICK_CYCLES),
      .CNT_W      (CNT_W)
   ) u_timer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (w_tmr_load),
      .i_prescale(w_tmr_prescale),
      .i_count   (w_tmr_count),
      .o_expire  (w_tmr_expire)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: every combinational output is defaulted first so no path can infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_tmr_load     = 1'b0;
      w_tmr_prescale = 1'b0;
      w_tmr_count    = CNT_W'(BUSY_TIMEOUT);
      w_fail         = 1'b0;
      case (r_state)
         IDLE:    if (i_start) w_state_nxt = FETCH;
         FETCH:   w_state_nxt = LATCH;
         LATCH:   w_state_nxt = ISSUE;
         ISSUE: begin
            w_tmr_load  = 1'b1;
            w_state_nxt = WAIT_HI;
         end
         WAIT_HI: begin
            if (i_i2c_busy)        w_state_nxt = WAIT_LO;
            else if (w_tmr_expire) w_fail      = 1'b1;
         end
         WAIT_LO: begin
            if (!i_i2c_busy) begin
               if (i_i2c_error)
                  w_fail = 1'b1;
               else if (r_delay == '0)
                  w_state_nxt = NEXT;
               else begin
                  w_tmr_load     = 1'b1;
                  w_tmr_prescale = 1'b1;
                  w_tmr_count    = CNT_W'(r_delay);
                  w_state_nxt    = DELAY;
               end
            end
         end
         DELAY:   if (w_tmr_expire) w_state_nxt = NEXT;
         NEXT: begin
            if (r_last || (r_tbl_idx == IDX_W'(NUM_CMDS - 1))) w_state_nxt = DONE;
            else                                               w_state_nxt = FETCH;
         end
         DONE:    w_state_nxt = IDLE;
         ERR:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (w_fail) w_state_nxt = w_retry_ok ? ISSUE : ERR;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tbl_idx  <= '0;
         r_fail_idx <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_delay    <= '0;
         r_last     <= 1'b0;
         r_wr_start <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
         r_retries   <= '0;
         r_retry_cnt <= '0;
`endif
      end else begin
         r_wr_start <= (w_state_nxt == ISSUE);
         case (r_state)
            IDLE: if (i_start) begin
               r_done     <= 1'b0;
               r_error    <= 1'b0;
               r_fail_idx <= '0;
               r_tbl_idx  <= '0;
               r_busy     <= 1'b1;
`ifdef I2C_SEQ_RETRY_EN
               r_retry_cnt <= '0;
`endif
            end
            LATCH: begin
               r_addr  <= i_tbl_entry[ADDR_MSB:ADDR_LSB];
               r_data  <= i_tbl_entry[DATA_MSB:DATA_LSB];
               r_delay <= i_tbl_entry[DLY_MSB:DLY_LSB];
               r_last  <= i_tbl_entry[LAST_BIT];
`ifdef I2C_SEQ_RETRY_EN
               r_retries <= '0;
`endif
            end
            NEXT: if (w_state_nxt == FETCH) r_tbl_idx <= r_tbl_idx + 1'b1;
            DONE: begin
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            ERR: begin
               r_error    <= 1'b1;
               r_fail_idx <= r_tbl_idx;
               r_busy     <= 1'b0;
            end
            default: ;
         endcase
`ifdef I2C_SEQ_RETRY_EN
         // Retry re-issues the entry already latched; the sequence total saturates.
         if (w_fail && w_retry_ok) begin
            r_retries <= r_retries + 1'b1;
            if (r_retry_cnt != 8'hFF) r_retry_cnt <= r_retry_cnt + 8'd1;
         end
`endif
      end
   end

   assign o_tbl_idx        = r_tbl_idx;
   assign o_fail_idx       = r_fail_idx;
   assign o_i2c_slave_addr = r_addr;
   assign o_i2c_wr_byte    = r_data;
   assign o_i2c_wr_start   = r_wr_start;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_error          = r_error;

endmodule
